// File: rtl/dat_pkg.sv
// Shared constants for the dat_rcv receive buffer: handshake FSM encodings and default sizing.
// No logic, no latency, no backpressure of its own.
// Optional RX_CNT statistics are enabled in dat_rcv by defining DAT_RCV_STAT_EN.
package dat_pkg;

    localparam int DAT_DATA_WIDTH = 8;
    localparam int DAT_DEPTH      = 16;
    localparam int DAT_SKID       = 2;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCEPT = 2'd1;
    localparam logic [1:0] S_PAUSE  = 2'd2;

endpackage

// File: rtl/dat_rcv_fifo.sv
// First-word-fall-through word buffer with registered level/empty/full and sticky overflow.
// Zero-cycle read latency; LEVEL/EMPTY/FULL update one cycle after the operation.
// Writes are never refused upstream: a write into a full buffer without a pop is dropped and flagged.
module dat_rcv_fifo
    import dat_pkg::*;
#(
    parameter int DATA_WIDTH = DAT_DATA_WIDTH,
    parameter int DEPTH      = DAT_DEPTH,
    localparam int AW        = $clog2(DEPTH),
    localparam int LW        = AW + 1
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_wr,
    input  logic [DATA_WIDTH-1:0] i_wr_dat,
    input  logic                  i_rd,
    output logic [DATA_WIDTH-1:0] o_rd_dat,
    output logic                  o_empty,
    output logic                  o_full,
    output logic [LW-1:0]         o_level,
    output logic [LW-1:0]         o_level_nxt,
    output logic                  o_ovf
);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]         r_wr_ptr;
    logic [AW-1:0]         r_rd_ptr;
    logic [LW-1:0]         r_level;
    logic                  r_empty;
    logic                  r_full;
    logic                  r_ovf;

    logic                  w_rd_ok;
    logic                  w_wr_ok;
    logic                  w_drop;
    logic [LW-1:0]         w_level_nxt;

    // A pop frees the slot in the same cycle, so a write at FULL is kept when paired with a pop.
    assign w_rd_ok = i_rd & ~r_empty;
    assign w_wr_ok = i_wr & ~i_rst & (~r_full | w_rd_ok);
    assign w_drop  = i_wr & ~i_rst & r_full & ~w_rd_ok;

    always_comb begin
        w_level_nxt = r_level;
        if (w_wr_ok && !w_rd_ok) begin
            w_level_nxt = r_level + LW'(1);
        end else if (!w_wr_ok && w_rd_ok) begin
            w_level_nxt = r_level - LW'(1);
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
            r_empty  <= 1'b1;
            r_full   <= 1'b0;
            r_ovf    <= 1'b0;
        end else begin
            if (w_wr_ok) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_rd_ok) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            r_level <= w_level_nxt;
            r_empty <= (w_level_nxt == '0);
            r_full  <= (w_level_nxt == LW'(DEPTH));
            if (w_drop) begin
                r_ovf <= 1'b1;
            end
        end
    end

    // Storage is deliberately left out of reset.
    always_ff @(posedge i_clk) begin
        if (w_wr_ok) begin
            r_mem[r_wr_ptr] <= i_wr_dat;
        end
    end

    assign o_rd_dat    = r_mem[r_rd_ptr];
    assign o_empty     = r_empty;
    assign o_full      = r_full;
    assign o_level     = r_level;
    assign o_level_nxt = w_level_nxt;
    assign o_ovf       = r_ovf;

endmodule

// File: rtl/dat_rcv.sv
// Receive front end: request/ready handshake FSM that keeps SKID free slots in front of dat_rcv_fifo.
// Zero-cycle read latency; I_REDAY is registered and reacts to the same edge that changes LEVEL.
// I_REDAY drops while free space <= SKID; late words still land. DAT_RCV_STAT_EN adds RX_CNT.
module dat_rcv
    import dat_pkg::*;
#(
    parameter int DATA_WIDTH = DAT_DATA_WIDTH,
    parameter int DEPTH      = DAT_DEPTH,
    parameter int SKID       = DAT_SKID,
    localparam int LW        = $clog2(DEPTH) + 1
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  I_REQ,
    output logic                  I_REDAY,
    input  logic                  I_DAT_EN,
    input  logic [DATA_WIDTH-1:0] I_DAT,
    input  logic                  RD_EN,
    output logic [DATA_WIDTH-1:0] RD_DAT,
    output logic                  EMPTY,
    output logic                  FULL,
    output logic [LW-1:0]         LEVEL,
    output logic                  OVF
`ifdef DAT_RCV_STAT_EN
    ,
    output logic [15:0]           RX_CNT
`endif
);

    logic [1:0]    r_state;
    logic [1:0]    w_state_nxt;
    logic          r_reday;
    logic [LW-1:0] w_level_nxt;
    logic [LW-1:0] w_free;
    logic          w_room;

    dat_rcv_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_fifo (
        .i_clk       (CLK),
        .i_rst       (RESET),
        .i_wr        (I_DAT_EN),
        .i_wr_dat    (I_DAT),
        .i_rd        (RD_EN),
        .o_rd_dat    (RD_DAT),
        .o_empty     (EMPTY),
        .o_full      (FULL),
        .o_level     (LEVEL),
        .o_level_nxt (w_level_nxt),
        .o_ovf       (OVF)
    );

    // Free space is judged on the post-operation level so the grant never lags a write.
    assign w_free = LW'(DEPTH) - w_level_nxt;
    assign w_room = (w_free > LW'(SKID));

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (I_REQ && w_room) begin
                    w_state_nxt = S_ACCEPT;
                end
            end
            S_ACCEPT: begin
                if (!I_REQ) begin
                    w_state_nxt = S_IDLE;
                end else if (!w_room) begin
                    w_state_nxt = S_PAUSE;
                end
            end
            S_PAUSE: begin
                if (w_room) begin
                    w_state_nxt = I_REQ ? S_ACCEPT : S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_state <= S_IDLE;
            r_reday <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_reday <= (w_state_nxt == S_ACCEPT);
        end
    end

    assign I_REDAY = r_reday;

`ifdef DAT_RCV_STAT_EN
    logic        w_wr_acc;
    logic [15:0] r_rx_cnt;

    assign w_wr_acc = I_DAT_EN & (~FULL | (RD_EN & ~EMPTY));

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_rx_cnt <= '0;
        end else if (w_wr_acc && (r_rx_cnt != 16'hFFFF)) begin
            r_rx_cnt <= r_rx_cnt + 16'd1;
        end
    end

    assign RX_CNT = r_rx_cnt;
`endif

endmodule

// File: tb/tb_dat_rcv.sv
// Scoreboard bench for dat_rcv: directed scenarios then randomized traffic against a queue-based model.
module tb_dat_rcv;

    localparam int DW    = 8;
    localparam int DEPTH = 16;
    localparam int SKID  = 2;
    localparam int LW    = $clog2(DEPTH) + 1;

    logic          CLK      = 1'b0;
    logic          RESET    = 1'b1;
    logic          I_REQ    = 1'b0;
    logic          I_DAT_EN = 1'b0;
    logic [DW-1:0] I_DAT    = '0;
    logic          RD_EN    = 1'b0;
    logic          I_REDAY;
    logic [DW-1:0] RD_DAT;
    logic          EMPTY;
    logic          FULL;
    logic [LW-1:0] LEVEL;
    logic          OVF;
`ifdef DAT_RCV_STAT_EN
    logic [15:0]   RX_CNT;
`endif

    dat_rcv #(
        .DATA_WIDTH (DW),
        .DEPTH      (DEPTH),
        .SKID       (SKID)
    ) dut (
        .CLK      (CLK),
        .RESET    (RESET),
        .I_REQ    (I_REQ),
        .I_REDAY  (I_REDAY),
        .I_DAT_EN (I_DAT_EN),
        .I_DAT    (I_DAT),
        .RD_EN    (RD_EN),
        .RD_DAT   (RD_DAT),
        .EMPTY    (EMPTY),
        .FULL     (FULL),
        .LEVEL    (LEVEL),
        .OVF      (OVF)
`ifdef DAT_RCV_STAT_EN
        ,
        .RX_CNT   (RX_CNT)
`endif
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic rdy;
        logic empty;
        logic full;
        logic ovf;
        int   lvl;
        int   rx;
    } st_t;

    int            checks = 0;
    int            errors = 0;
    st_t           st_q[$];
    logic [DW-1:0] exp_q[$];

    // Reference model: occupancy count, sticky overflow, grant, accepted-write count.
    int m_lvl = 0;
    bit m_ovf = 1'b0;
    bit m_rdy = 1'b0;
    int m_rx  = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // One clock of stimulus; records the status expected this cycle, then advances the model.
    task automatic cycle(input bit req, input bit en, input logic [DW-1:0] dat,
                         input bit rd, input bit rst);
        st_t s;
        bit  rd_ok;
        bit  wr_ok;
        @(posedge CLK);
        #1;
        I_REQ    = req;
        I_DAT_EN = en;
        I_DAT    = dat;
        RD_EN    = rd;
        RESET    = rst;
        if (rst) begin
            m_lvl = 0;
            m_ovf = 1'b0;
            m_rdy = 1'b0;
            m_rx  = 0;
            exp_q.delete();
        end
        s.rdy   = m_rdy;
        s.empty = (m_lvl == 0);
        s.full  = (m_lvl == DEPTH);
        s.ovf   = m_ovf;
        s.lvl   = m_lvl;
        s.rx    = m_rx;
        st_q.push_back(s);
        if (!rst) begin
            rd_ok = rd && (m_lvl > 0);
            wr_ok = en && ((m_lvl < DEPTH) || rd_ok);
            if (en && !wr_ok) m_ovf = 1'b1;
            if (wr_ok) begin
                exp_q.push_back(dat);
                if (m_rx < 65535) m_rx++;
            end
            m_lvl = m_lvl + int'(wr_ok) - int'(rd_ok);
            m_rdy = req && ((DEPTH - m_lvl) > SKID);
        end
    endtask

    // Monitor: per-cycle status against the model, and every DUT pop against the data scoreboard.
    initial begin : monitor
        st_t s;
        forever begin
            @(negedge CLK);
            if (st_q.size() > 0) begin
                s = st_q.pop_front();
                chk("i_reday", 32'(I_REDAY), 32'(s.rdy));
                chk("empty",   32'(EMPTY),   32'(s.empty));
                chk("full",    32'(FULL),    32'(s.full));
                chk("ovf",     32'(OVF),     32'(s.ovf));
                chk("level",   32'(LEVEL),   32'(s.lvl));
`ifdef DAT_RCV_STAT_EN
                chk("rx_cnt",  32'(RX_CNT),  32'(s.rx));
`endif
            end
            if (RD_EN && !EMPTY && !RESET) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL pop_when_model_empty actual=pop rd_dat=%0h required=no_pop", RD_DAT);
                end else begin
                    chk("rd_dat", 32'(RD_DAT), 32'(exp_q.pop_front()));
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "bench timeout");
    end

    initial begin : stim
        int rd_pct;
        bit rst;
        bit req;
        bit en;
        bit rd;

        for (int i = 0; i < 3; i++) cycle(0, 0, 8'h00, 0, 1);
        @(negedge CLK);
        chk("reset_empty",  32'(EMPTY),   32'd1);
        chk("reset_level",  32'(LEVEL),   32'd0);
        chk("reset_reday",  32'(I_REDAY), 32'd0);
        chk("reset_full",   32'(FULL),    32'd0);

        // Basic transfer
        cycle(1, 0, 8'h00, 0, 0);
        for (int i = 1; i <= 5; i++) cycle(1, 1, 8'(i), 0, 0);
        cycle(1, 0, 8'h00, 0, 0);
        @(negedge CLK);
        chk("basic_level", 32'(LEVEL),   32'd5);
        chk("basic_reday", 32'(I_REDAY), 32'd1);
        chk("basic_head",  32'(RD_DAT),  32'h01);
        for (int i = 0; i < 5; i++) cycle(0, 0, 8'h00, 1, 0);
        cycle(0, 0, 8'h00, 0, 0);
        @(negedge CLK);
        chk("basic_empty", 32'(EMPTY), 32'd1);

        // Backpressure: grant drops at 14, one trailing word lands
        for (int i = 0; i < 14; i++) cycle(1, 1, 8'(8'h10 + i), 0, 0);
        cycle(1, 1, 8'h1E, 0, 0);
        cycle(1, 0, 8'h00, 0, 0);
        @(negedge CLK);
        chk("bp_level", 32'(LEVEL),   32'd15);
        chk("bp_reday", 32'(I_REDAY), 32'd0);
        chk("bp_ovf",   32'(OVF),     32'd0);

        // Resume after two pops
        cycle(1, 0, 8'h00, 1, 0);
        cycle(1, 0, 8'h00, 1, 0);
        cycle(1, 0, 8'h00, 0, 0);
        @(negedge CLK);
        chk("resume_reday", 32'(I_REDAY), 32'd1);
        chk("resume_level", 32'(LEVEL),   32'd13);
        for (int i = 0; i < 13; i++) cycle(0, 0, 8'h00, 1, 0);
        cycle(0, 0, 8'h00, 0, 0);

        // Overflow: 17 forced writes
        for (int i = 0; i < 17; i++) cycle(0, 1, 8'(8'h40 + i), 0, 0);
        cycle(0, 0, 8'h00, 0, 0);
        @(negedge CLK);
        chk("ovf_flag",  32'(OVF),   32'd1);
        chk("ovf_full",  32'(FULL),  32'd1);
        chk("ovf_level", 32'(LEVEL), 32'd16);

        // Write and pop together at FULL
        cycle(0, 1, 8'hAA, 1, 0);
        cycle(0, 0, 8'h00, 0, 0);
        @(negedge CLK);
        chk("full_wr_rd_level", 32'(LEVEL), 32'd16);
        for (int i = 0; i < 16; i++) cycle(0, 0, 8'h00, 1, 0);
        cycle(0, 0, 8'h00, 0, 0);

        // Write and pop together at EMPTY
        cycle(0, 1, 8'h5C, 1, 0);
        cycle(0, 0, 8'h00, 0, 0);
        @(negedge CLK);
        chk("empty_wr_rd_level", 32'(LEVEL),  32'd1);
        chk("empty_wr_rd_dat",   32'(RD_DAT), 32'h5C);
        chk("empty_wr_rd_empty", 32'(EMPTY),  32'd0);
        cycle(0, 0, 8'h00, 1, 0);

        // Reset mid-burst
        for (int i = 0; i < 3; i++) cycle(1, 1, 8'(8'hC0 + i), 0, 0);
        cycle(1, 1, 8'hEE, 0, 1);
        cycle(1, 0, 8'h00, 0, 0);
        @(negedge CLK);
        chk("rst_mid_empty", 32'(EMPTY),   32'd1);
        chk("rst_mid_level", 32'(LEVEL),   32'd0);
        chk("rst_mid_reday", 32'(I_REDAY), 32'd0);
        chk("rst_mid_ovf",   32'(OVF),     32'd0);
`ifdef DAT_RCV_STAT_EN
        chk("rst_mid_rx_cnt", 32'(RX_CNT), 32'd0);
`endif

        // Randomized traffic with varying drain rate and rare resets
        for (int blk = 0; blk < 6; blk++) begin
            rd_pct = 15 + blk * 15;
            for (int i = 0; i < 100; i++) begin
                rst = ($urandom_range(0, 99) == 0);
                req = ($urandom_range(0, 3) != 0);
                en  = m_rdy ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 7) == 0);
                rd  = ($urandom_range(0, 99) < rd_pct);
                cycle(req, en, 8'($urandom), rd, rst);
            end
        end

        cycle(0, 0, 8'h00, 0, 0);
        cycle(0, 0, 8'h00, 0, 0);
        @(negedge CLK);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
